// File: rtl/hazard_detection_unit.sv
// rtl/hazard_detection_unit.sv - pipeline hazard detection with stall/flush control and stall counter
//
// Purpose:
//   Detects load-use hazards between EX and ID, and load-to-branch hazards between MEM and ID.
//   Outputs the PC/IF-ID hold, bubble-insert and IF/ID flush controls. Also keeps a saturating
//   count of the cycles spent stalled.
//
// Ports:
//   clk                  - single clock; all state updates happen on the rising edge
//   reset                - asynchronous active-high reset
//   ID_EX_reg_target_in  - destination register (rt) of the instruction in EX
//   IF_ID_reg_source_in  - rs of the instruction in ID
//   IF_ID_reg_target_in  - rt of the instruction in ID
//   EX_MEM_reg_target_in - destination register of the instruction in MEM
//   ID_EX_mem_read_in    - the instruction in EX is a load
//   EX_MEM_mem_read_in   - the instruction in MEM is a load
//   EX_MEM_WB_in         - the instruction in MEM writes the register file
//   branch_in            - the instruction in ID is a conditional branch
//   comparator_in        - the ID-stage branch comparator reports the branch as taken
//   jump_in              - the instruction in ID is a jump
//   PCWrite_out          - 1 = the PC may update, 0 = hold the PC
//   IF_ID_write_out      - 1 = the IF/ID register may load, 0 = hold it
//   MUX_nop_out          - 1 = zero the ID/EX control signals (insert a bubble)
//   flush_out            - 1 = flush IF/ID (discard the fetched instruction)
//   stall_cnt_out        - registered, saturating count of stall cycles

module hazard_detection_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ID_EX_reg_target_in,
    input  logic [4:0]  IF_ID_reg_source_in,
    input  logic [4:0]  IF_ID_reg_target_in,
    input  logic [4:0]  EX_MEM_reg_target_in,
    input  logic        ID_EX_mem_read_in,
    input  logic        EX_MEM_mem_read_in,
    input  logic        EX_MEM_WB_in,
    input  logic        branch_in,
    input  logic        comparator_in,
    input  logic        jump_in,
    output logic        PCWrite_out,
    output logic        IF_ID_write_out,
    output logic        MUX_nop_out,
    output logic        flush_out,
    output logic [15:0] stall_cnt_out
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic        w_ex_match;
    logic        w_mem_match;
    logic        w_load_use;
    logic        w_branch_load;
    logic        w_stall;
    logic        w_redirect;
    logic [15:0] r_stall_cnt;

    // Register 0 is hard-wired to zero, so a write to it can never be a real dependency.
    assign w_ex_match  = (ID_EX_reg_target_in != 5'd0) &&
                         ((ID_EX_reg_target_in == IF_ID_reg_source_in) ||
                          (ID_EX_reg_target_in == IF_ID_reg_target_in));

    assign w_mem_match = (EX_MEM_reg_target_in != 5'd0) &&
                         ((EX_MEM_reg_target_in == IF_ID_reg_source_in) ||
                          (EX_MEM_reg_target_in == IF_ID_reg_target_in));

    assign w_load_use = ID_EX_mem_read_in && w_ex_match;

    // The branch compares in ID, so a load still in MEM cannot be forwarded in time.
    // An ALU result in MEM (mem_read = 0) is forwarded and does not stall.
    assign w_branch_load = branch_in && EX_MEM_mem_read_in && EX_MEM_WB_in && w_mem_match;

    // Reset masks the hazard so that every output takes its reset value.
    assign w_stall = !reset && (w_load_use || w_branch_load);

    assign w_redirect = jump_in || (branch_in && comparator_in);

    assign PCWrite_out     = !w_stall;
    assign IF_ID_write_out = !w_stall;
    assign MUX_nop_out     = w_stall;
    // A stalled branch has not been resolved yet, so the stall takes priority over the flush.
    assign flush_out       = !reset && !w_stall && w_redirect;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt_out = r_stall_cnt;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb/tb_hazard_detection_unit.sv - self-checking bench for hazard_detection_unit
module tb_hazard_detection_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ID_EX_reg_target_in;
    logic [4:0]  IF_ID_reg_source_in;
    logic [4:0]  IF_ID_reg_target_in;
    logic [4:0]  EX_MEM_reg_target_in;
    logic        ID_EX_mem_read_in;
    logic        EX_MEM_mem_read_in;
    logic        EX_MEM_WB_in;
    logic        branch_in;
    logic        comparator_in;
    logic        jump_in;
    logic        PCWrite_out;
    logic        IF_ID_write_out;
    logic        MUX_nop_out;
    logic        flush_out;
    logic [15:0] stall_cnt_out;

    int errors = 0;
    int checks = 0;
    int unsigned model_cnt = 0;

    hazard_detection_unit dut (
        .clk                  (clk),
        .reset                (reset),
        .ID_EX_reg_target_in  (ID_EX_reg_target_in),
        .IF_ID_reg_source_in  (IF_ID_reg_source_in),
        .IF_ID_reg_target_in  (IF_ID_reg_target_in),
        .EX_MEM_reg_target_in (EX_MEM_reg_target_in),
        .ID_EX_mem_read_in    (ID_EX_mem_read_in),
        .EX_MEM_mem_read_in   (EX_MEM_mem_read_in),
        .EX_MEM_WB_in         (EX_MEM_WB_in),
        .branch_in            (branch_in),
        .comparator_in        (comparator_in),
        .jump_in              (jump_in),
        .PCWrite_out          (PCWrite_out),
        .IF_ID_write_out      (IF_ID_write_out),
        .MUX_nop_out          (MUX_nop_out),
        .flush_out            (flush_out),
        .stall_cnt_out        (stall_cnt_out)
    );

    always #5 clk = ~clk;

    // Reference model: the ID instruction reads a set of registers; a producer is
    // dangerous only if it targets a non-zero register in that set.
    function automatic bit id_reads(input logic [4:0] r);
        logic [4:0] readers [2];
        readers[0] = IF_ID_reg_source_in;
        readers[1] = IF_ID_reg_target_in;
        if (r == 5'd0) return 1'b0;
        foreach (readers[k]) if (readers[k] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_stall();
        bit ex_load_pending;
        bit mem_load_for_branch;
        if (reset) return 1'b0;
        ex_load_pending     = ID_EX_mem_read_in && id_reads(ID_EX_reg_target_in);
        mem_load_for_branch = branch_in && EX_MEM_mem_read_in && EX_MEM_WB_in &&
                              id_reads(EX_MEM_reg_target_in);
        return ex_load_pending || mem_load_for_branch;
    endfunction

    function automatic bit model_flush();
        if (reset || model_stall()) return 1'b0;
        return jump_in || (branch_in && comparator_in);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic apply(input logic [4:0] ex_t, input logic [4:0] id_s, input logic [4:0] id_t,
                         input logic [4:0] mem_t, input logic ex_mr, input logic mem_mr,
                         input logic mem_wb, input logic br, input logic cmp, input logic jmp);
        ID_EX_reg_target_in  = ex_t;
        IF_ID_reg_source_in  = id_s;
        IF_ID_reg_target_in  = id_t;
        EX_MEM_reg_target_in = mem_t;
        ID_EX_mem_read_in    = ex_mr;
        EX_MEM_mem_read_in   = mem_mr;
        EX_MEM_WB_in         = mem_wb;
        branch_in            = br;
        comparator_in        = cmp;
        jump_in              = jmp;
    endtask

    task automatic check_comb(input string tag);
        bit s;
        #1;
        s = model_stall();
        chk({tag, ".pcwrite"}, {15'd0, PCWrite_out},     {15'd0, ~s});
        chk({tag, ".ifidwr"},  {15'd0, IF_ID_write_out}, {15'd0, ~s});
        chk({tag, ".nop"},     {15'd0, MUX_nop_out},     {15'd0, s});
        chk({tag, ".flush"},   {15'd0, flush_out},       {15'd0, model_flush()});
    endtask

    // One rising edge with the current inputs; the model counter advances first.
    task automatic tick_model();
        bit s;
        s = model_stall();
        @(posedge clk);
        if (reset) model_cnt = 0;
        else if (s && model_cnt < 65535) model_cnt = model_cnt + 1;
    endtask

    task automatic tick(input string tag);
        tick_model();
        #1;
        chk({tag, ".cnt"}, stall_cnt_out, model_cnt[15:0]);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        // Load-use pattern present during reset: outputs must still be forced.
        apply(5'd5, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        chk("rst.pcwrite", {15'd0, PCWrite_out},     16'd1);
        chk("rst.ifidwr",  {15'd0, IF_ID_write_out}, 16'd1);
        chk("rst.nop",     {15'd0, MUX_nop_out},     16'd0);
        chk("rst.flush",   {15'd0, flush_out},       16'd0);
        chk("rst.cnt",     stall_cnt_out,            16'd0);
        tick("rst_hold");

        // Load-use stall held for 3 cycles.
        reset = 1'b0;
        apply(5'd5, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_comb("loaduse");
        chk("loaduse.nop_abs", {15'd0, MUX_nop_out}, 16'd1);
        tick("loaduse1");
        tick("loaduse2");
        tick("loaduse3");
        chk("cnt_is_3", stall_cnt_out, 16'd3);

        // Register 0 never creates a hazard.
        apply(5'd0, 5'd0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_comb("r0_load");
        chk("r0_load.nop_abs", {15'd0, MUX_nop_out}, 16'd0);
        tick("r0_load");

        // ALU result in MEM is forwarded: no stall even for a branch.
        apply(5'd0, 5'd3, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_comb("alu_fwd");
        tick("alu_fwd");

        // Branch two behind a load: stall, and no flush although the branch is taken.
        apply(5'd0, 5'd7, 5'd0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check_comb("br_load");
        chk("br_load.flush_abs", {15'd0, flush_out}, 16'd0);
        tick("br_load");

        // Taken branch, not-taken branch, jump: no hazards.
        apply(5'd0, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_comb("br_taken");
        chk("br_taken.flush_abs", {15'd0, flush_out}, 16'd1);
        apply(5'd0, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_comb("br_not_taken");
        apply(5'd0, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_comb("jump");
        // Jump during a load-use stall.
        apply(5'd4, 5'd4, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_comb("jump_stall");
        tick("jump_stall");

        // Saturation: drive the counter up to and past its ceiling.
        apply(5'd5, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 65540; i++) tick_model();
        #1;
        chk("sat.cnt", stall_cnt_out, model_cnt[15:0]);
        chk("sat.abs", stall_cnt_out, 16'hFFFF);
        @(negedge clk);
        tick("sat_hold");

        // Reset asserted mid-cycle during a stall.
        #2;
        reset = 1'b1;
        #1;
        model_cnt = 0;
        chk("midrst.cnt",     stall_cnt_out,            16'd0);
        chk("midrst.pcwrite", {15'd0, PCWrite_out},     16'd1);
        chk("midrst.nop",     {15'd0, MUX_nop_out},     16'd0);
        chk("midrst.flush",   {15'd0, flush_out},       16'd0);
        @(negedge clk);
        tick("midrst_hold");
        reset = 1'b0;
        check_comb("post_rst");
        tick("post_rst");

        // Randomized patterns on a narrow register range so matches are frequent.
        for (int i = 0; i < 400; i++) begin
            apply(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
            check_comb("rand");
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_detection_unit.md
HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port ID_EX_reg_target_in, input, 5 bits: destination register (rt) of the instruction in EX.
REQ-004 SHALL have port IF_ID_reg_source_in, input, 5 bits: rs of the instruction in ID.
REQ-005 SHALL have port IF_ID_reg_target_in, input, 5 bits: rt of the instruction in ID.
REQ-006 SHALL have port EX_MEM_reg_target_in, input, 5 bits: destination register of the instruction in MEM.
REQ-007 SHALL have port ID_EX_mem_read_in, input, 1 bit: the EX instruction is a load.
REQ-008 SHALL have port EX_MEM_mem_read_in, input, 1 bit: the MEM instruction is a load.
REQ-009 SHALL have port EX_MEM_WB_in, input, 1 bit: the MEM instruction writes the register file.
REQ-010 SHALL have port branch_in, input, 1 bit: the ID instruction is a conditional branch.
REQ-011 SHALL have port comparator_in, input, 1 bit: the ID-stage branch comparator reports the branch taken.
REQ-012 SHALL have port jump_in, input, 1 bit: the ID instruction is a jump.
REQ-013 SHALL have port PCWrite_out, output, 1 bit: 1 = PC may update, 0 = hold PC.
REQ-014 SHALL have port IF_ID_write_out, output, 1 bit: 1 = IF/ID register may load, 0 = hold.
REQ-015 SHALL have port MUX_nop_out, output, 1 bit: 1 = zero the ID/EX control signals (insert a bubble).
REQ-016 SHALL have port flush_out, output, 1 bit: 1 = flush IF/ID (discard the fetched instruction).
REQ-017 SHALL have port stall_cnt_out, output, 16 bits: registered count of stall cycles.

Function
REQ-018 SHALL define match_src(X) = (X == IF_ID_reg_source_in) and (X != 0); register 0 never creates a hazard.
REQ-019 SHALL define match_tgt(X) = (X == IF_ID_reg_target_in) and (X != 0).
REQ-020 SHALL define match(X) = match_src(X) or match_tgt(X).
REQ-021 SHALL assert load_use = ID_EX_mem_read_in and match(ID_EX_reg_target_in).
REQ-022 SHALL assert branch_load = branch_in and EX_MEM_mem_read_in and EX_MEM_WB_in and match(EX_MEM_reg_target_in), which covers a load two ahead of a branch.
REQ-023 SHALL define stall = load_use or branch_load.
REQ-024 SHALL NOT stall when EX_MEM_WB_in = 1 and EX_MEM_mem_read_in = 0, since ALU results are forwarded.
REQ-025 SHALL drive, while stall = 1: PCWrite_out = 0, IF_ID_write_out = 0, MUX_nop_out = 1.
REQ-026 SHALL drive, while stall = 0: PCWrite_out = 1, IF_ID_write_out = 1, MUX_nop_out = 0.
REQ-027 SHALL drive flush_out = not stall and (jump_in or (branch_in and comparator_in)).
REQ-028 SHALL give stall priority over flush; a jump or taken branch during a stall never asserts flush_out.
REQ-029 SHALL compute all of PCWrite_out, IF_ID_write_out, MUX_nop_out and flush_out combinationally, with zero-cycle latency.
REQ-030 SHALL increment stall_cnt_out by 1 on every rising clk edge where stall = 1.
REQ-031 SHALL saturate stall_cnt_out at 16'hFFFF with no wrap-around.

Reset
REQ-032 SHALL clear stall_cnt_out to 0 immediately on reset assertion, independent of clk.
REQ-033 SHALL force, while reset = 1: PCWrite_out = 1, IF_ID_write_out = 1, MUX_nop_out = 0, flush_out = 0.
REQ-034 SHALL hold stall_cnt_out at 0 while reset = 1.
REQ-035 SHALL resume normal evaluation of all outputs on the first cycle after reset is released, with no extra latency.

Verification
REQ-036 Load-use stall: ID_EX_mem_read_in=1, ID_EX_reg_target_in=5, IF_ID_reg_target_in=5 -> PCWrite_out=0, IF_ID_write_out=0, MUX_nop_out=1, flush_out=0; stall_cnt_out increments each clk.
REQ-037 Register 0 ignored: ID_EX_mem_read_in=1 with ID_EX_reg_target_in=0 and IF_ID_reg_source_in=0 -> no stall; likewise EX_MEM_WB_in=1, EX_MEM_mem_read_in=0, EX_MEM_reg_target_in=3, IF_ID_reg_source_in=3 -> no stall.
REQ-038 Branch after load: branch_in=1, EX_MEM_mem_read_in=1, EX_MEM_WB_in=1, EX_MEM_reg_target_in=7, IF_ID_reg_source_in=7, comparator_in=1 -> stall asserted, flush_out=0.
REQ-039 Taken branch and jump: branch_in=1, comparator_in=1 with no hazard -> flush_out=1, PCWrite_out=1; branch_in=1, comparator_in=0 -> flush_out=0; jump_in=1 -> flush_out=1.
REQ-040 Counter: hold a stall for 3 clks -> stall_cnt_out=3; preload to 16'hFFFF and stall further -> stays 16'hFFFF.
REQ-041 Reset mid-operation: assert reset during a stall -> stall_cnt_out=0 immediately and outputs take the reset values in REQ-033.
